data_cache_2way: RTL and testbench
==================================

Name: data_cache_2way

Overview:
- Parametrised two-way set-associative, write-through, no-write-allocate data cache.
- Sits between the memory controller (load/store requests) and unified memory.
- Handles BYTE/HALF/WORD accesses at any byte alignment, including accesses that span two cache lines.
- Multi-word lines, per-set LRU replacement, a flush input, and a valid/ready request side with a request/ack memory side.

Parameters:
ADDR_WIDTH, 17, byte address width
LEN, 32, data word width (bits)
LINE_WORDS, 2, words per cache line (power of two)
WORD_SEL_SIZE, 1, log2(LINE_WORDS)
SETS, 8, number of sets (power of two)
SET_INDEX_SIZE, 3, log2(SETS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  invalidate all lines; sampled in IDLE only
req_valid  in  1  request present
req_ready  out  1  cache can accept a request; equals (state==IDLE && !flush)
req_store  in  1  1=store, 0=load
data_type  in  3  `BYTE/`HALF/`WORD
addr  in  ADDR_WIDTH  byte address
wdata  in  LEN  store data, left-aligned (byte in [31:24], half in [31:16])
resp_valid  out  1  one-cycle pulse: request complete
rdata  out  LEN  load data, left-aligned, valid with resp_valid
hit  out  1  registered with resp_valid: 1 if served without refill
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=write
mem_addr  out  ADDR_WIDTH  reads: word-aligned; writes: request byte address
mem_wdata  out  LEN  left-aligned store data
mem_wtype  out  3  store data_type
mem_rdata  in  LEN  read word in memory order, valid when mem_ack
mem_ack  in  1  one-cycle completion pulse; only meaningful while mem_req=1

Behaviour:
- Line layout:
  - Line = 4*LINE_WORDS bytes. Lowest-offset byte sits in the MSBs.
  - Word k of a line = mem word at line_base+4k.
  - Address fields: offset = addr[WORD_SEL_SIZE+1:0]; index = next SET_INDEX_SIZE bits; tag = remaining bits.
- Access span:
  - Access covers n bytes (1/2/4) from addr.
  - If offset+n > line bytes, the access touches a second line at line_base+line_bytes. Index increments modulo SETS; the tag carries in when the index wraps (plain address addition).
  - The top address wraps modulo 2^ADDR_WIDTH.
- Lookup: a line is present if either way of its set is valid with a matching tag. Request hit = all touched lines present.
- LRU:
  - One bit per set, naming the victim way.
  - Updated to the other way on every hit access to a way and on every refill into a way.
  - Victim choice: the invalid way first (way 0 if both are invalid), else the LRU way.
- States: IDLE, REFILL, STORE, RESP.
- IDLE:
  - flush=1: clears all valid and LRU bits in one cycle; no request is accepted that cycle.
  - Otherwise, on req_valid&&req_ready, latch the request, then:
    - Load hit: go to RESP; rdata is assembled from the cache; hit=1; latency 1 cycle.
    - Load miss: go to REFILL for the first missing line.
    - Store: update cached bytes in every present touched line, then go to STORE.
- REFILL:
  - Issue LINE_WORDS reads at line_base, +4, ... with mem_req held.
  - On each mem_ack, write mem_rdata into the victim way's word and advance the address. mem_req stays high for the next word, so there is no bubble.
  - After the last word: set tag and valid, update LRU.
  - If the second touched line is also missing, refill it the same way; then go to RESP with hit=0.
- STORE:
  - mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata, mem_wtype=data_type.
  - On mem_ack go to RESP. hit=1 iff all touched lines were present.
  - A store miss allocates nothing.
- RESP: resp_valid=1 for one cycle, then return to IDLE.
- Illegal data_type: RESP next cycle with rdata=0 and hit=0; no memory access and no state change.
- req_valid while req_ready=0 is ignored (the requester must hold it).
- mem_req is registered, so mem_ack can arrive no earlier than the first cycle mem_req is high.
- Reset (async, any time, including mid-REFILL/STORE): state=IDLE, all valid=0, LRU=0, and every output = 0 except req_ready, which follows its definition. A partially refilled line stays invalid.

Test Plan:
- Memory model: word 0x10=0x11223344, 0x14=0x55667788, 0x18=0x99AABBCC.
- Cold load WORD 0x10 -> reads at 0x10 and 0x14; rdata=0x11223344, hit=0. Then load HALF 0x13 -> resp 1 cycle after accept, rdata=0x44550000, hit=1, no mem_req.
- Spanning load WORD 0x16 (line 0x10 cached, 0x18 not) -> reads at 0x18 and 0x1C only; rdata=0x7788_99AA, hit=0.
- Conflict: load 0x10, 0x50, 0x90 (all set 2) -> the third access evicts line 0x10. A reload of 0x50 hits; a reload of 0x10 misses.
- Store BYTE 0x11, wdata=0xEE000000, after line 0x10 cached -> one mem write (addr 0x11, wtype BYTE), hit=1. Then load WORD 0x10 hits with rdata=0x11EE3344. A store to uncached 0x40 -> write only; a later load of 0x40 misses.
- flush, then load 0x10 -> miss with refill. Illegal data_type -> rdata=0, hit=0, no mem_req.
- Assert rst_n=0 during the second refill read -> mem_req drops immediately. After reset, load 0x10 misses and refills.

Source files
------------

// File: rtl/data_cache_2way.sv
// data_cache_2way: two-way set-associative, write-through, no-write-allocate
// data cache. Byte/half/word accesses may sit at any alignment and may
// straddle two consecutive lines. Refills stream LINE_WORDS reads per line.

`ifndef BYTE
`define BYTE 3'b000
`endif
`ifndef HALF
`define HALF 3'b001
`endif
`ifndef WORD
`define WORD 3'b010
`endif

module data_cache_2way #(
    parameter int ADDR_WIDTH     = 17,
    parameter int LEN            = 32,
    parameter int LINE_WORDS     = 2,
    parameter int WORD_SEL_SIZE  = 1,
    parameter int SETS           = 8,
    parameter int SET_INDEX_SIZE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            data_type,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN-1:0]        wdata,
    output logic                  resp_valid,
    output logic [LEN-1:0]        rdata,
    output logic                  hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LEN-1:0]        mem_wdata,
    output logic [2:0]            mem_wtype,
    input  logic [LEN-1:0]        mem_rdata,
    input  logic                  mem_ack
);
    localparam int LINE_BYTES = 4 * LINE_WORDS;
    localparam int LINE_BITS  = 8 * LINE_BYTES;
    localparam int OFF_W      = WORD_SEL_SIZE + 2;
    localparam int TAG_W      = ADDR_WIDTH - OFF_W - SET_INDEX_SIZE;
    localparam int CNT_W      = (WORD_SEL_SIZE > 0) ? WORD_SEL_SIZE : 1;

    // Handshakes: a request transfers on the clk edge where req_valid && req_ready;
    // the requester holds its request until then. On the memory side mem_req and
    // its address/data stay stable until the edge that samples mem_ack=1.

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_STORE, S_RESP} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN-1:0]        wdata_q;
    logic [2:0]            type_q;
    logic                  store_q, illegal_q, hit_q, miss_b_q;
    logic                  ref_line_q, ref_line_d;   // 0: first touched line, 1: second
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0][SETS-1:0]  valid_q;
    logic [SETS-1:0]       lru_q;                    // names the victim way per set
    logic [TAG_W-1:0]      tag_q  [2][SETS];
    logic [LINE_BITS-1:0]  line_q [2][SETS];

    logic [ADDR_WIDTH-1:0]     lk_addr, base_a, base_b, ref_base;
    logic [2:0]                lk_type;
    logic [OFF_W-1:0]          off_a;
    logic [SET_INDEX_SIZE-1:0] idx_a, idx_b, ref_idx;
    logic [TAG_W-1:0]          tag_a, tag_b, ref_tag;
    int                        n_bytes;
    logic legal, span, m_a0, m_a1, m_b0, m_b1;
    logic present_a, present_b, all_present, way_a, way_b, vic;
    logic accept, refill_last;

    // Address split and tag match, on the incoming request in IDLE, else the latched one
    always_comb begin
        lk_addr = (state_q == S_IDLE) ? addr : addr_q;
        lk_type = (state_q == S_IDLE) ? data_type : type_q;
        case (lk_type)
            `BYTE:   n_bytes = 1;
            `HALF:   n_bytes = 2;
            `WORD:   n_bytes = 4;
            default: n_bytes = 0;
        endcase
        legal     = (n_bytes != 0);
        off_a     = lk_addr[OFF_W-1:0];
        base_a    = {lk_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        base_b    = base_a + ADDR_WIDTH'(LINE_BYTES);
        idx_a     = base_a[OFF_W +: SET_INDEX_SIZE];
        idx_b     = base_b[OFF_W +: SET_INDEX_SIZE];
        tag_a     = base_a[ADDR_WIDTH-1 -: TAG_W];
        tag_b     = base_b[ADDR_WIDTH-1 -: TAG_W];
        span      = legal && ((int'(off_a) + n_bytes) > LINE_BYTES);
        m_a0      = valid_q[0][idx_a] && (tag_q[0][idx_a] == tag_a);
        m_a1      = valid_q[1][idx_a] && (tag_q[1][idx_a] == tag_a);
        m_b0      = valid_q[0][idx_b] && (tag_q[0][idx_b] == tag_b);
        m_b1      = valid_q[1][idx_b] && (tag_q[1][idx_b] == tag_b);
        present_a = m_a0 || m_a1;
        present_b = m_b0 || m_b1;
        way_a     = !m_a0;
        way_b     = !m_b0;
        all_present = present_a && (!span || present_b);
        ref_base  = ref_line_q ? base_b : base_a;
        ref_idx   = ref_base[OFF_W +: SET_INDEX_SIZE];
        ref_tag   = ref_base[ADDR_WIDTH-1 -: TAG_W];
        if (!valid_q[0][ref_idx])      vic = 1'b0;
        else if (!valid_q[1][ref_idx]) vic = 1'b1;
        else                           vic = lru_q[ref_idx];
    end

    logic [LINE_BITS-1:0] line_a_cur, line_b_cur, line_a_new, line_b_new;
    logic [LEN-1:0]       rdata_asm;
    int                   pos;

    // Byte gather for loads and byte merge for store hits across both touched lines
    always_comb begin
        line_a_cur = line_q[way_a][idx_a];
        line_b_cur = line_q[way_b][idx_b];
        line_a_new = line_a_cur;
        line_b_new = line_b_cur;
        rdata_asm  = '0;
        pos        = 0;
        for (int j = 0; j < 4; j++) begin
            if (j < n_bytes) begin
                pos = int'(off_a) + j;
                if (pos < LINE_BYTES) begin
                    rdata_asm[LEN-8-8*j +: 8] = line_a_cur[LINE_BITS-8-8*pos +: 8];
                    line_a_new[LINE_BITS-8-8*pos +: 8] = wdata[LEN-8-8*j +: 8];
                end else begin
                    rdata_asm[LEN-8-8*j +: 8] = line_b_cur[LINE_BITS-8-8*(pos-LINE_BYTES) +: 8];
                    line_b_new[LINE_BITS-8-8*(pos-LINE_BYTES) +: 8] = wdata[LEN-8-8*j +: 8];
                end
            end
        end
    end

    assign accept      = (state_q == S_IDLE) && !flush && req_valid;
    assign refill_last = (state_q == S_REFILL) && mem_ack && (cnt_q == CNT_W'(LINE_WORDS - 1));

    // Next-state logic for the request FSM
    always_comb begin
        state_d    = state_q;
        ref_line_d = ref_line_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!legal)         state_d = S_RESP;
                    else if (req_store) state_d = S_STORE;
                    else if (all_present) state_d = S_RESP;
                    else begin
                        state_d    = S_REFILL;
                        ref_line_d = present_a;
                        cnt_d      = '0;
                    end
                end
            end
            S_REFILL: begin
                if (mem_ack) begin
                    if (refill_last) begin
                        cnt_d = '0;
                        if (!ref_line_q && miss_b_q) ref_line_d = 1'b1;
                        else                         state_d    = S_RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_STORE: if (mem_ack) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched request, valid and LRU bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            type_q     <= '0;
            store_q    <= 1'b0;
            illegal_q  <= 1'b0;
            hit_q      <= 1'b0;
            miss_b_q   <= 1'b0;
            ref_line_q <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= '0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            ref_line_q <= ref_line_d;
            cnt_q      <= cnt_d;
            if (state_q == S_IDLE && flush) begin
                valid_q <= '0;
                lru_q   <= '0;
            end
            if (accept) begin
                addr_q    <= addr;
                wdata_q   <= wdata;
                type_q    <= data_type;
                store_q   <= req_store;
                illegal_q <= !legal;
                hit_q     <= legal && all_present;
                miss_b_q  <= span && !present_b;
                if (legal && present_a)         lru_q[idx_a] <= !way_a;
                if (legal && span && present_b) lru_q[idx_b] <= !way_b;
            end
            if (refill_last) begin
                valid_q[vic][ref_idx] <= 1'b1;
                lru_q[ref_idx]        <= !vic;
            end
        end
    end

    // Line data and tags: store-hit byte merge and refill word fills
    always_ff @(posedge clk) begin
        if (accept && legal && req_store) begin
            if (present_a)         line_q[way_a][idx_a] <= line_a_new;
            if (span && present_b) line_q[way_b][idx_b] <= line_b_new;
        end
        if (state_q == S_REFILL && mem_ack) begin
            line_q[vic][ref_idx][LINE_BITS-LEN-LEN*int'(cnt_q) +: LEN] <= mem_rdata;
            if (refill_last) tag_q[vic][ref_idx] <= ref_tag;
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !flush;
    assign resp_valid = (state_q == S_RESP);
    assign hit        = resp_valid && hit_q;
    assign rdata      = (resp_valid && !store_q && !illegal_q) ? rdata_asm : '0;
    assign mem_req    = (state_q == S_REFILL) || (state_q == S_STORE);
    assign mem_we     = (state_q == S_STORE);
    assign mem_addr   = (state_q == S_REFILL) ? ref_base + (ADDR_WIDTH'(cnt_q) << 2) :
                        (state_q == S_STORE)  ? addr_q : '0;
    assign mem_wdata  = (state_q == S_STORE) ? wdata_q : '0;
    assign mem_wtype  = (state_q == S_STORE) ? type_q : '0;

endmodule

// File: tb/tb_data_cache_2way.sv
// Bench for data_cache_2way: directed scenarios followed by random traffic,
// checked against a line-level LRU model and a byte-addressed memory image.

`ifndef BYTE
`define BYTE 3'b000
`endif
`ifndef HALF
`define HALF 3'b001
`endif
`ifndef WORD
`define WORD 3'b010
`endif

module tb_data_cache_2way;
    localparam int AW    = 17;
    localparam int AMASK = (1 << AW) - 1;

    logic          clk, rst_n, flush, req_valid, req_ready, req_store;
    logic [2:0]    data_type;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          resp_valid, hit;
    logic [31:0]   rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [2:0]    mem_wtype;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem_b [0:(1<<AW)-1];
    logic [AW:0] exp_q[$];      // {we, addr} of expected memory operations
    logic [34:0] exp_wd_q[$];   // {wtype, wdata} for expected writes
    int          m_line [8][2]; // per set: [0]=most recent line base, [1]=older, -1 empty
    int          ack_limit = -1;

    data_cache_2way dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .data_type(data_type), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata), .hit(hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wtype(mem_wtype),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model of residency
    function automatic int set_of(int base);
        return (base / 8) % 8;
    endfunction
    function automatic bit m_present(int base);
        int s = set_of(base);
        return (m_line[s][0] == base) || (m_line[s][1] == base);
    endfunction
    function automatic void m_touch(int base);
        int s = set_of(base);
        if (m_line[s][1] == base) begin
            m_line[s][1] = m_line[s][0];
            m_line[s][0] = base;
        end
    endfunction
    function automatic void m_insert(int base);
        int s = set_of(base);
        m_line[s][1] = m_line[s][0];
        m_line[s][0] = base;
    endfunction
    function automatic void m_clear();
        for (int s = 0; s < 8; s++) begin
            m_line[s][0] = -1;
            m_line[s][1] = -1;
        end
    endfunction
    function automatic void push_reads(int base);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b0, AW'((base + 4 * k) & AMASK)});
            exp_wd_q.push_back('0);
        end
    endfunction
    function automatic int nbytes(logic [2:0] ty);
        if (ty == `BYTE) return 1;
        if (ty == `HALF) return 2;
        if (ty == `WORD) return 4;
        return 0;
    endfunction

    // memory responder: random ack delay, checks each operation against exp_q
    initial begin : mem_resp
        int          wc;
        int          wa;
        logic [AW:0] e;
        logic [34:0] ewd;
        wc = -1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = '0;
            if (!rst_n || !mem_req) begin
                wc = -1;
            end else if (ack_limit != 0) begin
                if (wc < 0) wc = $urandom_range(0, 2);
                if (wc == 0) begin
                    wc = -1;
                    if (ack_limit > 0) ack_limit--;
                    if (exp_q.size() == 0) begin
                        check_eq("mem_unexpected", {mem_we, mem_addr}, '1);
                    end else begin
                        e = exp_q.pop_front();
                        ewd = exp_wd_q.pop_front();
                        check_eq("mem_op", {mem_we, mem_addr}, e);
                        if (e[AW]) check_eq("mem_wdata", {mem_wtype, mem_wdata}, ewd);
                    end
                    wa = int'(mem_addr) & ~3;
                    mem_rdata = {mem_b[wa], mem_b[(wa + 1) & AMASK],
                                 mem_b[(wa + 2) & AMASK], mem_b[(wa + 3) & AMASK]};
                    mem_ack = 1'b1;
                end else begin
                    wc--;
                end
            end
        end
    end

    // driver: one request, model expectations, response checks
    task automatic do_req(input logic st, input logic [2:0] ty, input logic [AW-1:0] a,
                          input logic [31:0] wd, output logic [31:0] got_rd, output logic got_hit);
        int n, la, lb, cyc, lat;
        bit span, pa, pb;
        logic [31:0] exp_rd;
        bit exp_hit;
        n = nbytes(ty);
        exp_rd = '0;
        exp_hit = 1'b0;
        if (n != 0) begin
            la = int'(a) & ~7;
            lb = (la + 8) & AMASK;
            span = ((int'(a) % 8) + n) > 8;
            pa = m_present(la);
            pb = span ? m_present(lb) : 1'b1;
            exp_hit = pa && pb;
            if (pa) m_touch(la);
            if (span && pb) m_touch(lb);
            if (st) begin
                exp_q.push_back({1'b1, a});
                exp_wd_q.push_back({ty, wd});
                for (int j = 0; j < n; j++) mem_b[(int'(a) + j) & AMASK] = wd[31-8*j -: 8];
            end else begin
                if (!pa) begin push_reads(la); m_insert(la); end
                if (span && !pb) begin push_reads(lb); m_insert(lb); end
                for (int j = 0; j < n; j++) exp_rd[31-8*j -: 8] = mem_b[(int'(a) + j) & AMASK];
            end
        end
        @(negedge clk);
        req_valid = 1'b1; req_store = st; data_type = ty; addr = a; wdata = wd;
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; addr = AW'($urandom); wdata = $urandom; data_type = 3'($urandom);
        req_store = 1'($urandom);
        lat = 1;
        while (!resp_valid && lat < 60) begin @(negedge clk); lat++; end
        got_rd = rdata;
        got_hit = hit;
        if (!resp_valid) begin
            check_eq("resp_timeout", 0, 1);
        end else begin
            check_eq("rdata", rdata, exp_rd);
            check_eq("hit", hit, exp_hit);
            if ((n == 0) || (!st && exp_hit)) check_eq("latency", lat, 1);
        end
        @(negedge clk);
        check_eq("resp_pulse", resp_valid, 0);
        check_eq("mem_ops_left", exp_q.size(), 0);
        exp_q.delete();
        exp_wd_q.delete();
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_store = 1'b0; data_type = `WORD; addr = 17'h10;
        #1 check_eq("flush_ready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        check_eq("flush_no_accept", {resp_valid, mem_req}, 0);
        m_clear();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        logic hh;
        int cyc;
        bit found;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_store = 1'b0;
        data_type = `WORD; addr = '0; wdata = '0;
        m_clear();
        for (int i = 0; i < (1 << AW); i++) mem_b[i] = 8'($urandom);
        {mem_b[16], mem_b[17], mem_b[18], mem_b[19]} = 32'h11223344;
        {mem_b[20], mem_b[21], mem_b[22], mem_b[23]} = 32'h55667788;
        {mem_b[24], mem_b[25], mem_b[26], mem_b[27]} = 32'h99AABBCC;

        // reset values
        #12;
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_outs", {resp_valid, hit, rdata, mem_req, mem_we}, 0);
        check_eq("rst_mem", {mem_addr, mem_wdata, mem_wtype}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // cold load, then a hit that straddles a word boundary
        do_req(0, `WORD, 17'h10, 0, rd, hh);
        check_eq("plan_cold", {hh, rd}, {1'b0, 32'h11223344});
        do_req(0, `HALF, 17'h13, 0, rd, hh);
        check_eq("plan_half", {hh, rd}, {1'b1, 32'h44550000});
        // line-spanning load, second line refilled
        do_req(0, `WORD, 17'h16, 0, rd, hh);
        check_eq("plan_span", {hh, rd}, {1'b0, 32'h778899AA});
        // conflict in set 2
        do_req(0, `WORD, 17'h50, 0, rd, hh);
        do_req(0, `WORD, 17'h90, 0, rd, hh);
        do_req(0, `WORD, 17'h50, 0, rd, hh);
        check_eq("plan_50_hit", hh, 1);
        do_req(0, `WORD, 17'h10, 0, rd, hh);
        check_eq("plan_10_miss", hh, 0);
        // stores
        do_req(1, `BYTE, 17'h11, 32'hEE000000, rd, hh);
        check_eq("plan_st_hit", hh, 1);
        do_req(0, `WORD, 17'h10, 0, rd, hh);
        check_eq("plan_st_load", {hh, rd}, {1'b1, 32'h11EE3344});
        do_req(1, `WORD, 17'h40, 32'hCAFEF00D, rd, hh);
        check_eq("plan_st_miss", hh, 0);
        do_req(0, `WORD, 17'h40, 0, rd, hh);
        check_eq("plan_40_miss", {hh, rd}, {1'b0, 32'hCAFEF00D});
        // flush and illegal type
        do_flush();
        do_req(0, `WORD, 17'h10, 0, rd, hh);
        check_eq("plan_flush_miss", hh, 0);
        do_req(0, 3'b111, 17'h10, 0, rd, hh);
        check_eq("plan_illegal", {hh, rd}, 0);
        // address wrap at the top of memory
        do_req(0, `WORD, 17'h1FFFE, 0, rd, hh);
        do_req(0, `HALF, 17'h1FFFF, 0, rd, hh);

        // reset in the middle of a refill
        do_flush();
        @(negedge clk);
        ack_limit = 1;
        push_reads(16);
        req_valid = 1'b1; req_store = 1'b0; data_type = `WORD; addr = 17'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 40) begin
            if (mem_req && mem_addr == 17'h14) found = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        check_eq("rst_second_read", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_req", {mem_req, mem_we, resp_valid, hit}, 0);
        check_eq("rst_mid_ready", req_ready, 1);
        check_eq("rst_mid_addr", mem_addr, 0);
        exp_q.delete();
        exp_wd_q.delete();
        m_clear();
        ack_limit = -1;
        @(negedge clk);
        rst_n = 1'b1;
        do_req(0, `WORD, 17'h10, 0, rd, hh);
        check_eq("rst_reload", {hh, rd}, {1'b0, 32'h11EE3344});

        // random traffic
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [2:0] ty;
            logic [AW-1:0] a;
            logic st;
            if ($urandom_range(0, 99) < 3) do_flush();
            r = $urandom_range(0, 9);
            ty = (r < 3) ? `BYTE : (r < 6) ? `HALF : (r < 9) ? `WORD : 3'($urandom_range(3, 7));
            if ($urandom_range(0, 9) == 0) a = AW'(32'h1FFF0 + $urandom_range(0, 15));
            else                           a = AW'($urandom_range(0, 255));
            st = ($urandom_range(0, 9) < 3);
            do_req(st, ty, a, $urandom, rd, hh);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
